// File: rtl/mux_sel_rr_arbiter_if.sv
// Handshake bundle between the four mux sources, the arbiter and the mux.
interface mux_sel_rr_arbiter_if;
  logic       En;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic       S1;
  logic       S0;
  logic       Valid;

  // Requesting side: drives enable and requests, observes grant and select.
  modport master (
    output En,
    output Req,
    input  Gnt,
    input  S1,
    input  S0,
    input  Valid
  );

  // Arbiter side.
  modport slave (
    input  En,
    input  Req,
    output Gnt,
    output S1,
    output S0,
    output Valid
  );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 2-bit 4x1 mux with bounded dwell per grant.
module mux_sel_rr_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  mux_sel_rr_arbiter_if.slave  arb
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IDX_W  = 2;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] gnt_q;
  logic [IDX_W-1:0]  sel_q;
  logic              valid_q;

  logic              pick_found_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic [IDX_W-1:0]  cand_c;
  logic              do_load_c;
  logic              do_release_c;
  logic              do_dec_c;

  // Round-robin search starting after the last owner; last owner is checked last.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = ptr_q;
    cand_c       = ptr_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!pick_found_c && arb.Req[cand_c]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand_c;
      end
    end
  end

  // Per-edge action: load a new grant, release, or count down the dwell.
  always_comb begin
    do_load_c    = 1'b0;
    do_release_c = 1'b0;
    do_dec_c     = 1'b0;
    case (state_q)
      IDLE: begin
        do_load_c = arb.En && pick_found_c;
      end
      GRANT: begin
        if (!arb.En) begin
          do_release_c = 1'b1;
        end else if (!arb.Req[ptr_q] || (cnt_q == '0)) begin
          // Hand over in the same edge so Valid has no bubble.
          if (pick_found_c) begin
            do_load_c = 1'b1;
          end else begin
            do_release_c = 1'b1;
          end
        end else begin
          do_dec_c = 1'b1;
        end
      end
      default: begin
        do_release_c = 1'b1;
      end
    endcase
  end

  // Arbiter state and registered outputs; select holds its value while idle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_CH - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (do_load_c) begin
      state_q <= GRANT;
      ptr_q   <= pick_idx_c;
      cnt_q   <= HOLD_LOAD;
      gnt_q   <= NUM_CH'(1) << pick_idx_c;
      sel_q   <= pick_idx_c;
      valid_q <= 1'b1;
    end else if (do_release_c) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (do_dec_c) begin
      cnt_q   <= cnt_q - CNT_W'(1);
    end
  end

  assign arb.Gnt   = gnt_q;
  assign arb.S1    = sel_q[1];
  assign arb.S0    = sel_q[0];
  assign arb.Valid = valid_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter: dwell 4 instance plus a dwell 1 instance.
module tb_mux_sel_rr_arbiter;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   failures;

  mux_sel_rr_arbiter_if if4 ();
  mux_sel_rr_arbiter_if if1 ();

  mux_sel_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) u_dut4 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .arb   (if4.slave)
  );

  mux_sel_rr_arbiter #(.HOLD_CYCLES(1), .CNT_W(4)) u_dut1 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .arb   (if1.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packed view: {0, Valid, S1, S0, Gnt[3:0]}
  function automatic logic [7:0] obs4();
    return {1'b0, if4.Valid, if4.S1, if4.S0, if4.Gnt};
  endfunction

  function automatic logic [7:0] obs1();
    return {1'b0, if1.Valid, if1.S1, if1.S0, if1.Gnt};
  endfunction

  function automatic logic [7:0] exp_gnt(input int ch);
    logic [1:0] s;
    logic [3:0] g;
    s = 2'(ch);
    g = 4'b0001 << s;
    return {1'b0, 1'b1, s, g};
  endfunction

  function automatic logic [7:0] exp_idle(input logic [1:0] s);
    return {1'b0, 1'b0, s, 4'b0000};
  endfunction

  function automatic logic inv_ok(input logic v, input logic [1:0] s, input logic [3:0] g);
    logic ok;
    ok = $onehot0(g) && (v == (g != 4'b0000));
    if (v && !g[s]) ok = 1'b0;
    return ok;
  endfunction

  // Invariants on both instances every cycle.
  always @(negedge Clk) begin
    chk("inv4", 8'(inv_ok(if4.Valid, {if4.S1, if4.S0}, if4.Gnt)), 8'd1);
    chk("inv1", 8'(inv_ok(if1.Valid, {if1.S1, if1.S0}, if1.Gnt)), 8'd1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst_n    = 1'b0;
    if4.En   = 1'b0;
    if4.Req  = 4'b0000;
    if1.En   = 1'b0;
    if1.Req  = 4'b0000;

    #12;
    chk("reset_state", obs4(), exp_idle(2'b00));
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single requester on channel 2: re-granted after each dwell, Valid stays high.
    if4.En  = 1'b1;
    if4.Req = 4'b0100;
    step();
    chk("single_first", obs4(), exp_gnt(2));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("single_hold", obs4(), exp_gnt(2));
    end
    if4.Req = 4'b0000;
    step();
    chk("single_drop_idle", obs4(), exp_idle(2'b10));

    // All four requesting: 4-cycle dwell each, rotating from channel 0.
    do_reset();
    if4.Req = 4'b1111;
    for (int k = 0; k <= 16; k++) begin
      step();
      chk("rr_all", obs4(), exp_gnt((k / 4) % 4));
    end

    // Early release of owner 1 hands straight to channel 0.
    if4.Req = 4'b0000;
    do_reset();
    if4.Req = 4'b0010;
    step();
    chk("early_own1", obs4(), exp_gnt(1));
    if4.Req = 4'b0011;
    step();
    chk("early_hold_a", obs4(), exp_gnt(1));
    step();
    chk("early_hold_b", obs4(), exp_gnt(1));
    if4.Req = 4'b0001;
    step();
    chk("early_handover", obs4(), exp_gnt(0));

    // Enable drop during grant of channel 3, then resume after ptr=3.
    if4.Req = 4'b0000;
    do_reset();
    if4.Req = 4'b1000;
    step();
    chk("en_own3", obs4(), exp_gnt(3));
    if4.En = 1'b0;
    step();
    chk("en_low_release", obs4(), exp_idle(2'b11));
    if4.En  = 1'b1;
    if4.Req = 4'b1001;
    step();
    chk("en_resume_ch0", obs4(), exp_gnt(0));

    // Asynchronous reset mid-cycle during grant of channel 2.
    if4.Req = 4'b0000;
    do_reset();
    if4.Req = 4'b0100;
    step();
    chk("arst_own2", obs4(), exp_gnt(2));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_immediate", obs4(), exp_idle(2'b00));
    if4.Req = 4'b1111;
    @(negedge Clk);
    Rst_n = 1'b1;
    step();
    chk("arst_restart_ch0", obs4(), exp_gnt(0));

    // Dwell of 1 with two requesters alternates every edge.
    if4.En  = 1'b0;
    if4.Req = 4'b0000;
    do_reset();
    if1.En  = 1'b1;
    if1.Req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("hold1_alt", obs1(), exp_gnt((k % 2 == 0) ? 1 : 3));
    end
    if1.Req = 4'b0000;
    step();
    chk("hold1_idle", obs1(), exp_idle(2'b11));

    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sel_rr_arbiter.md
Name: mux_sel_rr_arbiter

Overview:
- Round-robin select generator sitting directly upstream of the 2-bit 4x1 mux.
- Takes per-channel requests from the four 2-bit sources (A..D) and drives the mux select pair S1/S0, a one-hot grant back to the sources, and a valid strobe to the consumer of the mux output.
- Each granted channel keeps the mux for a bounded dwell time, so all four sources get fair access.

Parameters:
HOLD_CYCLES, 4, maximum consecutive cycles a grant is held; legal range 1..15.
CNT_W, 4, dwell counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
Clk      input   1  system clock, rising edge.
Rst_n    input   1  reset; asynchronous assert, active-low.
En       input   1  arbiter enable; when low, no new grants and any current grant is released.
Req      input   4  per-channel request; bit0=A, bit1=B, bit2=C, bit3=D.
Gnt      output  4  one-hot registered grant, or all zero.
S1       output  1  mux select MSB; drives the mux S1 input.
S0       output  1  mux select LSB; drives the mux S0 input.
Valid    output  1  high while a grant is active, meaning the mux output is meaningful.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - Gnt=0000, S1S0=00, Valid=0.
  - Internal last-grant pointer = 3, so the first search starts at channel 0.
  - Dwell counter = 0, state IDLE.
  - Outputs change immediately on assert. Release is synchronous to Clk.
- All outputs are registered. A request sampled at edge k is reflected on the outputs immediately after edge k: one-cycle latency, no combinational Req-to-Gnt path.
- Round-robin pick:
  - Search order starts at ptr+1 and wraps modulo 4: ptr+1, ptr+2, ptr+3, ptr.
  - The first channel with Req high wins.
  - The current owner is reconsidered last, so it only wins again when it is the sole requester.
- Grant load action (on a pick of channel c):
  - Gnt = one-hot(c), {S1,S0} = c, Valid = 1, ptr = c.
  - Dwell counter = HOLD_CYCLES-1.
- State IDLE:
  - If En=1 and Req≠0: perform the pick and the grant load, go to GRANT.
  - Otherwise stay in IDLE with Valid=0 and Gnt=0000.
  - S1S0 hold their last value and do not return to 00.
- State GRANT, owner g. At each edge, evaluate in priority order:
  1. En=0: release. Gnt=0000, Valid=0, go to IDLE.
  2. Req[g]=0 (early release), or dwell counter == 0 (dwell expired): release and re-arbitrate in the same edge.
     - If any Req is high, perform the pick and the grant load. No idle bubble; Valid stays 1.
     - Otherwise go to IDLE, Gnt=0000, Valid=0.
  3. Else: decrement the dwell counter and hold all outputs.
- Dwell count:
  - With a continuously held request, the owner keeps its grant for exactly HOLD_CYCLES cycles.
  - HOLD_CYCLES=1 means the grant rotates every cycle when several channels request.
- Invariants:
  - Gnt is never multi-hot.
  - Valid=1 if and only if Gnt≠0.
  - When Valid=1, {S1,S0} equals the index of the set Gnt bit.
- Simultaneous events:
  - A new requester appearing in the same cycle as the owner drops its request is eligible in that cycle's pick.
  - Req changes mid-dwell on non-owner channels do not disturb the current grant.
- Reset mid-grant: all outputs clear immediately. After release, arbitration restarts from channel 0.

Test Plan:
- Reset, then Req=0100, En=1 → after 1 edge: Gnt=0100, S1S0=10, Valid=1. Hold Req=0100 for 10 cycles → grant re-issued to channel 2 after each 4-cycle dwell; Valid stays 1 throughout.
- Req=1111 held for 16 cycles, HOLD_CYCLES=4 → S1S0 sequence 00,01,10,11, each lasting exactly 4 cycles, then back to 00. Gnt one-hot matches S1S0 on every cycle.
- Owner 1 granted with Req=0011, Req[1] dropped after 2 cycles → next edge: Gnt=0001, S1S0=00, with no Valid=0 cycle in between.
- En driven low during a grant of channel 3 → next edge: Gnt=0000, Valid=0, S1S0 stays 11. En back to 1 with Req=1001 → channel 0 granted, since search starts after ptr=3.
- Rst_n pulsed low mid-edge-cycle during a grant of channel 2 → Gnt=0000, Valid=0, S1S0=00 immediately, before any Clk edge. After release with Req=1111 → channel 0 is granted first.
- HOLD_CYCLES=1 with Req=1010 → grant alternates 1,3,1,3 on every edge. Bench checks the invariants on every cycle: one-hot Gnt, Valid equivalence, and S1S0 consistency with Gnt.
